// File: rtl/router_fsm_np_if.sv
// Handshake bundle between the input register block, the router
// control FSM and the synchronizer/FIFO bank.
interface router_fsm_np_if #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 2
);
  logic               pkt_valid;
  logic [ADDR_W-1:0]  data_in;
  logic               fifo_full;
  logic [N_PORTS-1:0] fifo_empty;
  logic [N_PORTS-1:0] soft_reset;
  logic               parity_done;
  logic               low_packet_valid;

  logic               write_enb_reg;
  logic               detect_add;
  logic               ld_state;
  logic               laf_state;
  logic               lfd_state;
  logic               full_state;
  logic               rst_int_reg;
  logic               busy;
  logic               drop_state;
  logic [ADDR_W-1:0]  addr_reg;
  logic               timeout_err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty,
    output soft_reset, parity_done, low_packet_valid,
    input  write_enb_reg, detect_add, ld_state, laf_state,
    input  lfd_state, full_state, rst_int_reg, busy,
    input  drop_state, addr_reg, timeout_err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty,
    input  soft_reset, parity_done, low_packet_valid,
    output write_enb_reg, detect_add, ld_state, laf_state,
    output lfd_state, full_state, rst_int_reg, busy,
    output drop_state, addr_reg, timeout_err
  );
endinterface

// File: rtl/router_fsm_np.sv
// N-port router control FSM: latched header address, invalid-port
// drop and bounded wait-for-empty with a timeout pulse.
module router_fsm_np #(
  parameter int N_PORTS    = 3,
  parameter int ADDR_W     = 2,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input logic             clock,
  input logic             resetn,
  router_fsm_np_if.slave  bus
);
  localparam int NA = 2 ** ADDR_W;

  localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] LOAD_DATA          = 4'd2;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd3;
  localparam logic [3:0] LOAD_PARITY        = 4'd4;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'd5;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'd6;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'd7;
  localparam logic [3:0] DROP_PACKET        = 4'd8;

  logic [3:0]        ps_q, ns_d, nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              lim_hit;

  // Pad per-port vectors to the full address space so any
  // address indexes safely; missing ports read as 0.
  logic [NA-1:0] empty_pad, srst_pad, valid_pad;
  assign empty_pad = NA'(bus.fifo_empty);
  assign srst_pad  = NA'(bus.soft_reset);
  assign valid_pad = NA'({N_PORTS{1'b1}});

  assign lim_hit = (WAIT_LIMIT != 0) &&
                   (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_comb begin
    nxt = ps_q;
    case (ps_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          if (!valid_pad[bus.data_in])
            nxt = DROP_PACKET;
          else if (empty_pad[bus.data_in])
            nxt = LOAD_FIRST_DATA;
          else
            nxt = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)
          nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid)
          nxt = LOAD_PARITY;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_pad[addr_q])
          nxt = LOAD_FIRST_DATA;
        else if (lim_hit)
          nxt = DROP_PACKET;
      end
      LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        nxt = bus.fifo_full ? FIFO_FULL_STATE
                            : DECODE_ADDRESS;
      FIFO_FULL_STATE:
        if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)
          nxt = DECODE_ADDRESS;
        else if (bus.low_packet_valid)
          nxt = LOAD_PARITY;
        else
          nxt = LOAD_DATA;
      end
      DROP_PACKET:
        if (!bus.pkt_valid) nxt = DECODE_ADDRESS;
      default: nxt = DECODE_ADDRESS;
    endcase
  end

  always_comb begin
    ns_d = nxt;
    if (ps_q != DECODE_ADDRESS && srst_pad[addr_q])
      ns_d = DECODE_ADDRESS;
    addr_d = addr_q;
    if (ps_q == DECODE_ADDRESS && bus.pkt_valid)
      addr_d = bus.data_in;
    cnt_d = '0;
    if (ps_q == WAIT_TILL_EMPTY && ns_d == WAIT_TILL_EMPTY)
      cnt_d = cnt_q + CNT_W'(1);
    tmo_d = (ps_q == WAIT_TILL_EMPTY) &&
            (ns_d == DROP_PACKET);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ps_q   <= DECODE_ADDRESS;
      addr_q <= '0;
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
    end else begin
      ps_q   <= ns_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.detect_add  = ps_q == DECODE_ADDRESS;
  assign bus.lfd_state   = ps_q == LOAD_FIRST_DATA;
  assign bus.ld_state    = ps_q == LOAD_DATA;
  assign bus.laf_state   = ps_q == LOAD_AFTER_FULL;
  assign bus.full_state  = ps_q == FIFO_FULL_STATE;
  assign bus.rst_int_reg = ps_q == CHECK_PARITY_ERROR;
  assign bus.drop_state  = ps_q == DROP_PACKET;

  assign bus.write_enb_reg = (ps_q == LOAD_DATA) ||
                             (ps_q == LOAD_PARITY) ||
                             (ps_q == LOAD_AFTER_FULL);

  assign bus.busy = (ps_q == LOAD_FIRST_DATA) ||
                    (ps_q == WAIT_TILL_EMPTY) ||
                    (ps_q == LOAD_PARITY) ||
                    (ps_q == CHECK_PARITY_ERROR) ||
                    (ps_q == FIFO_FULL_STATE) ||
                    (ps_q == LOAD_AFTER_FULL);

  assign bus.addr_reg    = addr_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_router_fsm_np.sv
// Bench for router_fsm_np: directed packet scenarios plus random
// traffic against a phase-level model, with and without timeout.
module tb_router_fsm_np;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_fsm_np_if #(.N_PORTS(3), .ADDR_W(2)) bus_a ();
  router_fsm_np_if #(.N_PORTS(3), .ADDR_W(2)) bus_b ();

  router_fsm_np #(
    .N_PORTS(3), .ADDR_W(2), .WAIT_LIMIT(16), .CNT_W(5)
  ) dut (
    .clock(clock), .resetn(resetn), .bus(bus_a.slave)
  );

  router_fsm_np #(
    .N_PORTS(3), .ADDR_W(2), .WAIT_LIMIT(0), .CNT_W(5)
  ) dut_nolim (
    .clock(clock), .resetn(resetn), .bus(bus_b.slave)
  );

  assign bus_b.pkt_valid        = bus_a.pkt_valid;
  assign bus_b.data_in          = bus_a.data_in;
  assign bus_b.fifo_full        = bus_a.fifo_full;
  assign bus_b.fifo_empty       = bus_a.fifo_empty;
  assign bus_b.soft_reset       = bus_a.soft_reset;
  assign bus_b.parity_done      = bus_a.parity_done;
  assign bus_b.low_packet_valid = bus_a.low_packet_valid;

  typedef enum int {
    P_DEC, P_LFD, P_LD, P_WAIT, P_LP,
    P_CPE, P_FFS, P_LAF, P_DROP
  } ph_t;

  ph_t m_ph[2], n_ph[2];
  int  m_addr[2], n_addr[2];
  int  m_cnt[2], n_cnt[2];
  bit  m_tmo[2], n_tmo[2];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {timeout, addr, write, detect, ld, laf, lfd, full, rst_int, busy, drop}
  function automatic logic [11:0] exp_outs(int k);
    logic [8:0] s;
    case (m_ph[k])
      P_DEC:   s = 9'b010000000;
      P_LFD:   s = 9'b000010010;
      P_LD:    s = 9'b101000000;
      P_WAIT:  s = 9'b000000010;
      P_LP:    s = 9'b100000010;
      P_CPE:   s = 9'b000000110;
      P_FFS:   s = 9'b000001010;
      P_LAF:   s = 9'b100100010;
      default: s = 9'b000000001;
    endcase
    return {m_tmo[k], 2'(m_addr[k]), s};
  endfunction

  function automatic logic [11:0] obs_outs(int k);
    if (k == 0)
      return {bus_a.timeout_err, bus_a.addr_reg,
              bus_a.write_enb_reg, bus_a.detect_add,
              bus_a.ld_state, bus_a.laf_state,
              bus_a.lfd_state, bus_a.full_state,
              bus_a.rst_int_reg, bus_a.busy,
              bus_a.drop_state};
    return {bus_b.timeout_err, bus_b.addr_reg,
            bus_b.write_enb_reg, bus_b.detect_add,
            bus_b.ld_state, bus_b.laf_state,
            bus_b.lfd_state, bus_b.full_state,
            bus_b.rst_int_reg, bus_b.busy,
            bus_b.drop_state};
  endfunction

  function automatic bit port_bit(logic [2:0] v, int a);
    return (a < 3) ? v[a] : 1'b0;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int lim;
      lim = (k == 0) ? 16 : 0;
      n_ph[k]   = m_ph[k];
      n_addr[k] = m_addr[k];
      n_cnt[k]  = 0;
      n_tmo[k]  = 1'b0;
      if (!resetn) begin
        n_ph[k]   = P_DEC;
        n_addr[k] = 0;
      end else if (m_ph[k] != P_DEC &&
                   port_bit(bus_a.soft_reset, m_addr[k])) begin
        n_ph[k] = P_DEC;
      end else begin
        case (m_ph[k])
          P_DEC: if (bus_a.pkt_valid) begin
            n_addr[k] = int'(bus_a.data_in);
            if (n_addr[k] >= 3) n_ph[k] = P_DROP;
            else if (bus_a.fifo_empty[n_addr[k]]) n_ph[k] = P_LFD;
            else n_ph[k] = P_WAIT;
          end
          P_LFD: n_ph[k] = P_LD;
          P_LD:
            if (bus_a.fifo_full) n_ph[k] = P_FFS;
            else if (!bus_a.pkt_valid) n_ph[k] = P_LP;
          P_WAIT:
            if (bus_a.fifo_empty[m_addr[k]]) n_ph[k] = P_LFD;
            else if (lim != 0 && m_cnt[k] == lim - 1) begin
              n_ph[k]  = P_DROP;
              n_tmo[k] = 1'b1;
            end else n_cnt[k] = m_cnt[k] + 1;
          P_LP:  n_ph[k] = P_CPE;
          P_CPE: n_ph[k] = bus_a.fifo_full ? P_FFS : P_DEC;
          P_FFS: if (!bus_a.fifo_full) n_ph[k] = P_LAF;
          P_LAF:
            if (bus_a.parity_done) n_ph[k] = P_DEC;
            else if (bus_a.low_packet_valid) n_ph[k] = P_LP;
            else n_ph[k] = P_LD;
          default: if (!bus_a.pkt_valid) n_ph[k] = P_DEC;
        endcase
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      m_ph[k]   = n_ph[k];
      m_addr[k] = n_addr[k];
      m_cnt[k]  = n_cnt[k];
      m_tmo[k]  = n_tmo[k];
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check("outs_lim", 32'(obs_outs(0)), 32'(exp_outs(0)));
    check("outs_nolim", 32'(obs_outs(1)), 32'(exp_outs(1)));
    model_step();
    @(posedge clock);
    #1;
    commit();
  endtask

  task automatic set_idle();
    bus_a.pkt_valid        = 1'b0;
    bus_a.data_in          = 2'd0;
    bus_a.fifo_full        = 1'b0;
    bus_a.fifo_empty       = 3'b111;
    bus_a.soft_reset       = 3'b000;
    bus_a.parity_done      = 1'b0;
    bus_a.low_packet_valid = 1'b0;
  endtask

  initial begin
    int wr, dcnt, bad, wa, wb, tp, tpd, dseen;
    resetn = 1'b0;
    set_idle();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_DEC; m_addr[k] = 0;
      m_cnt[k] = 0;    m_tmo[k] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    check("reset_outs", 32'(obs_outs(0)), 32'h080);

    // full packet to port 1
    bus_a.pkt_valid = 1'b1;
    bus_a.data_in   = 2'd1;
    tick();
    check("hdr_lfd", 32'(bus_a.lfd_state), 32'd1);
    wr = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) bus_a.pkt_valid = 1'b0;
      bus_a.data_in = 2'($urandom);
      tick();
      wr += int'(bus_a.write_enb_reg);
    end
    check("pkt_writes", 32'(wr), 32'd5);
    check("pkt_end_dec", 32'(bus_a.detect_add), 32'd1);
    check("pkt_addr", 32'(bus_a.addr_reg), 32'd1);

    // wait uses latched address, not live data_in
    bus_a.pkt_valid  = 1'b1;
    bus_a.data_in    = 2'd2;
    bus_a.fifo_empty = 3'b011;
    tick();
    bus_a.data_in = 2'd0;
    repeat (3) tick();
    check("wait_hold",
          32'({bus_a.busy, bus_a.lfd_state, bus_a.addr_reg}),
          32'b1010);
    bus_a.fifo_empty = 3'b111;
    tick();
    check("wait_release", 32'(bus_a.lfd_state), 32'd1);
    tick();
    bus_a.pkt_valid = 1'b0;
    repeat (3) tick();

    // drop to nonexistent port 3
    bus_a.pkt_valid = 1'b1;
    bus_a.data_in   = 2'd3;
    tick();
    dcnt = int'(bus_a.drop_state);
    bad  = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.data_in = 2'($urandom);
      tick();
      dcnt += int'(bus_a.drop_state);
      bad  += int'(bus_a.busy | bus_a.write_enb_reg |
                   bus_a.lfd_state);
    end
    bus_a.pkt_valid = 1'b0;
    tick();
    check("drop_cycles", 32'(dcnt), 32'd5);
    check("drop_quiet", 32'(bad), 32'd0);
    check("drop_end_dec", 32'(bus_a.detect_add), 32'd1);

    // timeout on a stuck port 0
    bus_a.pkt_valid  = 1'b1;
    bus_a.data_in    = 2'd0;
    bus_a.fifo_empty = 3'b110;
    tick();
    bus_a.pkt_valid = 1'b0;
    wa = int'(bus_a.busy);
    wb = int'(bus_b.busy);
    tp = 0; tpd = 0; dseen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      wa    += int'(bus_a.busy);
      wb    += int'(bus_b.busy);
      tp    += int'(bus_a.timeout_err | bus_b.timeout_err);
      tpd   += int'(bus_a.timeout_err & bus_a.drop_state);
      dseen += int'(bus_a.drop_state);
    end
    check("tmo_wait_cycles", 32'(wa), 32'd16);
    check("tmo_pulses", 32'(tp), 32'd1);
    check("tmo_in_drop", 32'(tpd), 32'd1);
    check("tmo_drop_seen", 32'(dseen), 32'd1);
    check("nolim_waits", 32'(wb), 32'd41);
    bus_a.fifo_empty = 3'b111;
    repeat (5) tick();

    // soft reset: other port ignored, own port aborts
    bus_a.pkt_valid = 1'b1;
    bus_a.data_in   = 2'd1;
    repeat (2) tick();
    bus_a.soft_reset = 3'b100;
    tick();
    check("srst_other", 32'(bus_a.ld_state), 32'd1);
    bus_a.soft_reset = 3'b010;
    tick();
    check("srst_own",
          32'({bus_a.detect_add, bus_a.addr_reg}), 32'b101);
    bus_a.soft_reset = 3'b000;
    bus_a.pkt_valid  = 1'b0;
    tick();

    // full stall, resume with low_packet_valid
    bus_a.pkt_valid = 1'b1;
    bus_a.data_in   = 2'd0;
    repeat (2) tick();
    bus_a.fifo_full = 1'b1;
    repeat (2) tick();
    check("ffs", 32'(bus_a.full_state), 32'd1);
    bus_a.fifo_full        = 1'b0;
    bus_a.low_packet_valid = 1'b1;
    tick();
    check("laf", 32'(bus_a.laf_state), 32'd1);
    tick();
    check("laf_to_lp",
          32'({bus_a.write_enb_reg, bus_a.busy, bus_a.ld_state}),
          32'b110);
    bus_a.low_packet_valid = 1'b0;
    bus_a.pkt_valid        = 1'b0;
    tick();
    check("cpe", 32'(bus_a.rst_int_reg), 32'd1);
    tick();

    // reset while stalled in FIFO_FULL_STATE
    bus_a.pkt_valid = 1'b1;
    bus_a.data_in   = 2'd2;
    repeat (2) tick();
    bus_a.fifo_full = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    check("rst_in_ffs",
          32'({bus_a.detect_add, bus_a.addr_reg}), 32'b100);
    resetn = 1'b1;
    set_idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      resetn                 = $urandom_range(0, 63) != 0;
      bus_a.pkt_valid        = $urandom_range(0, 3) != 0;
      bus_a.data_in          = 2'($urandom);
      bus_a.fifo_full        = $urandom_range(0, 4) == 0;
      bus_a.fifo_empty       = 3'($urandom);
      bus_a.soft_reset       = ($urandom_range(0, 15) == 0) ?
                               3'($urandom) : 3'b000;
      bus_a.parity_done      = $urandom_range(0, 2) == 0;
      bus_a.low_packet_valid = $urandom_range(0, 2) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised next-generation router control FSM for N_PORTS destination FIFOs; generalises the 3-port controller.
- Latches the header address once and uses the latched value for the rest of the packet.
- Drops packets addressed to non-existent ports.
- Bounds the wait-for-empty phase with a timeout.
- Sits between the input register block (parity/low_packet_valid) and the synchronizer/FIFO bank; all outputs are decoded from the present state.

Parameters:
N_PORTS, 3, number of destination FIFOs (2..2**ADDR_W)
ADDR_W, 2, header address field width (data_in[ADDR_W-1:0])
WAIT_LIMIT, 16, max consecutive cycles in WAIT_TILL_EMPTY before drop; 0 disables timeout
CNT_W, 5, wait counter width; must hold WAIT_LIMIT

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  synchronous active-low reset
pkt_valid  in  1  source packet valid
data_in  in  ADDR_W  header address field of input byte
fifo_full  in  1  full flag of currently selected FIFO
fifo_empty  in  N_PORTS  per-port FIFO empty flags
soft_reset  in  N_PORTS  per-port read-timeout soft reset
parity_done  in  1  parity byte already written
low_packet_valid  in  1  pkt_valid fell while FIFO full
write_enb_reg  out  1  FIFO write enable request
detect_add  out  1  in DECODE_ADDRESS
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
lfd_state  out  1  in LOAD_FIRST_DATA
full_state  out  1  in FIFO_FULL_STATE
rst_int_reg  out  1  in CHECK_PARITY_ERROR
busy  out  1  stall source
drop_state  out  1  in DROP_PACKET
addr_reg  out  ADDR_W  latched destination address
timeout_err  out  1  one-cycle pulse on wait timeout

Behaviour:
- Reset: resetn sampled low on a rising clock edge -> PS=DECODE_ADDRESS, addr_reg=0, wait counter=0, timeout_err=0. Outputs after reset: detect_add=1, all other 1-bit outputs 0.
- Next-state priority: resetn, then soft_reset[addr_reg] while PS!=DECODE_ADDRESS (-> DECODE_ADDRESS), then NS. Soft resets of other ports are ignored. Soft reset is ignored while in DECODE_ADDRESS.
- Address latch: in DECODE_ADDRESS with pkt_valid=1, addr_reg<=data_in. After that, all port lookups use addr_reg, never live data_in.
- Valid address: addr < N_PORTS.
- Nine states, 4-bit encoding:
  - DECODE_ADDRESS:
    - pkt_valid && valid addr && fifo_empty[addr] -> LOAD_FIRST_DATA
    - pkt_valid && valid addr && !empty -> WAIT_TILL_EMPTY
    - pkt_valid && invalid addr -> DROP_PACKET
    - else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - WAIT_TILL_EMPTY:
    - fifo_empty[addr_reg] -> LOAD_FIRST_DATA
    - else if WAIT_LIMIT!=0 and counter==WAIT_LIMIT-1 -> DROP_PACKET, with timeout_err=1 for that one cycle (registered, asserted the cycle after the transition edge)
    - else stay, counter++.
    - Counter clears on every entry to WAIT_TILL_EMPTY and in all other states.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - else low_packet_valid -> LOAD_PARITY
    - else -> LOAD_DATA.
  - DROP_PACKET: pkt_valid=1 -> stay (bytes discarded); pkt_valid=0 (parity byte) -> DECODE_ADDRESS.
  - Illegal encodings -> DECODE_ADDRESS.
- Output decode (combinational from PS):
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = LOAD_FIRST_DATA | WAIT_TILL_EMPTY | LOAD_PARITY | CHECK_PARITY_ERROR | FIFO_FULL_STATE | LOAD_AFTER_FULL.
  - busy=0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET, so the source streams during a drop.
  - write_enb_reg=0 and lfd_state=0 throughout a drop.
- Latency: header accepted -> lfd_state at next edge; first payload write one cycle later.
- Soft reset mid-packet: the FSM abandons the packet and returns to DECODE_ADDRESS the next cycle. addr_reg holds its value until the next header is latched.

Test Plan:
- Header addr=1, fifo_empty=3'b111, 4 payload bytes, then pkt_valid=0 -> DECODE, LFD, LD x4, LP, CPE, DECODE; write_enb_reg high 5 cycles.
- Header addr=2, fifo_empty[2]=0, then data_in changed to 0 while fifo_empty[0]=1 -> FSM stays in WAIT (uses addr_reg=2); fifo_empty[2]=1 -> LOAD_FIRST_DATA.
- Header addr=3 (N_PORTS=3), 5 bytes -> DROP_PACKET for 5 cycles, busy=0, write_enb_reg=0, return to DECODE after pkt_valid=0.
- addr=0, fifo_empty[0] held 0, WAIT_LIMIT=16 -> 16 cycles in WAIT, then DROP_PACKET and timeout_err single pulse; WAIT_LIMIT=0 -> waits indefinitely.
- In LOAD_DATA with addr_reg=1: soft_reset=3'b100 -> no effect; soft_reset=3'b010 -> DECODE_ADDRESS next cycle.
- fifo_full in LOAD_DATA -> FFS; release with low_packet_valid=1, parity_done=0 -> LAF, LP, CPE; resetn=0 in FFS -> DECODE_ADDRESS, addr_reg=0.
